is_unique: RTL and testbench



---
 rtl/is_unique.sv | 96 +++++++++
 tb/tb_is_unique.sv | 132 +++++++++++++
 2 files changed

// File: rtl/is_unique.sv
// is_unique: registered BCD one-digit add, three-digit sum and 3x3 digit uniqueness check.
// Build option: define IS_UNIQUE_RANGE_CHECK_EN to require a permutation of 1..9 for unique_valid.
module is_unique (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic [3:0] num4,
  input  logic [3:0] num5,
  input  logic [3:0] num6,
  input  logic [3:0] num7,
  input  logic [3:0] num8,
  input  logic [3:0] num9,
  output logic [3:0] add_sum,
  output logic       add_valid,
  output logic [3:0] sum3,
  output logic       sum3_valid,
  output logic       unique_valid,
  output logic       out_valid
);
  logic [3:0] add_sum_d, add_sum_q, sum3_d, sum3_q;
  logic add_valid_d, add_valid_q, sum3_valid_d, sum3_valid_q;
  logic unique_valid_d, unique_valid_q, out_valid_d, out_valid_q;
  logic [4:0] s;
  logic [5:0] t;
  logic [3:0] d [9];
  logic uq;
`ifdef IS_UNIQUE_RANGE_CHECK_EN
  logic [8:0] pres;
  logic rng_ok;
`else
  logic [15:0] pres;
`endif
  function automatic logic [3:0] mod10(input logic [5:0] v);
    logic [5:0] r;
    r = v >= 6'd40 ? v - 6'd40 :
        v >= 6'd30 ? v - 6'd30 :
        v >= 6'd20 ? v - 6'd20 :
        v >= 6'd10 ? v - 6'd10 : v;
    return r[3:0];
  endfunction
  assign d = '{num1, num2, num3, num4, num5, num6, num7, num8, num9};
`ifdef IS_UNIQUE_RANGE_CHECK_EN
  always_comb begin
    pres = '0;
    rng_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (d[i] >= 4'd1 && d[i] <= 4'd9) pres[d[i] - 4'd1] = 1'b1;
      else rng_ok = 1'b0;
    end
    uq = rng_ok && pres == 9'h1FF;
  end
`else
  always_comb begin
    pres = '0;
    for (int i = 0; i < 9; i++) pres[d[i]] = 1'b1;
    uq = $countones(pres) == 9;
  end
`endif
  // t is the true three-digit total, so any stage overflow also shows up as t > 9
  always_comb begin
    s = {1'b0, num1} + {1'b0, num2};
    t = {1'b0, s} + {2'b0, num3};
    add_sum_d = en ? mod10({1'b0, s}) : add_sum_q;
    add_valid_d = en ? (num1 <= 4'd9 && num2 <= 4'd9 && s <= 5'd9) : add_valid_q;
    sum3_d = en ? mod10(t) : sum3_q;
    sum3_valid_d = en ? (num1 <= 4'd9 && num2 <= 4'd9 && num3 <= 4'd9 && t <= 6'd9) : sum3_valid_q;
    unique_valid_d = en ? uq : unique_valid_q;
    out_valid_d = en | out_valid_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      add_sum_q <= '0;
      add_valid_q <= 1'b0;
      sum3_q <= '0;
      sum3_valid_q <= 1'b0;
      unique_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      add_sum_q <= add_sum_d;
      add_valid_q <= add_valid_d;
      sum3_q <= sum3_d;
      sum3_valid_q <= sum3_valid_d;
      unique_valid_q <= unique_valid_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign add_sum = add_sum_q;
  assign add_valid = add_valid_q;
  assign sum3 = sum3_q;
  assign sum3_valid = sum3_valid_q;
  assign unique_valid = unique_valid_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_is_unique.sv
// tb_is_unique: table-driven scoreboard bench for is_unique.
module tb_is_unique;
  logic clock, reset, en;
  logic [3:0] num1, num2, num3, num4, num5, num6, num7, num8, num9;
  logic [3:0] add_sum, sum3;
  logic add_valid, sum3_valid, unique_valid, out_valid;
  typedef struct packed {
    logic [3:0] as;
    logic       av;
    logic [3:0] s3;
    logic       s3v;
    logic       uq;
  } exp_t;
  typedef struct packed {
    logic [35:0] g;
    exp_t        e;
  } vec_t;
  localparam logic RC = `ifdef IS_UNIQUE_RANGE_CHECK_EN 1'b1 `else 1'b0 `endif ;
  vec_t vecs [17];
  exp_t sb [$];
  exp_t last, zero;
  int errors = 0, checks = 0;
  is_unique dut (
    .clock(clock), .reset(reset), .en(en),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4), .num5(num5),
    .num6(num6), .num7(num7), .num8(num8), .num9(num9),
    .add_sum(add_sum), .add_valid(add_valid), .sum3(sum3), .sum3_valid(sum3_valid),
    .unique_valid(unique_valid), .out_valid(out_valid)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask
  task automatic check_outputs(input string tag, input exp_t e, input logic ov);
    chk({tag, ".add_sum"}, {4'd0, add_sum}, {4'd0, e.as});
    chk({tag, ".add_valid"}, {7'd0, add_valid}, {7'd0, e.av});
    chk({tag, ".sum3"}, {4'd0, sum3}, {4'd0, e.s3});
    chk({tag, ".sum3_valid"}, {7'd0, sum3_valid}, {7'd0, e.s3v});
    chk({tag, ".unique_valid"}, {7'd0, unique_valid}, {7'd0, e.uq});
    chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
  endtask
  task automatic set_grid(input logic [35:0] g);
    {num1, num2, num3, num4, num5, num6, num7, num8, num9} = g;
  endtask
  task automatic apply(input int i);
    exp_t e;
    @(negedge clock);
    set_grid(vecs[i].g);
    en = 1'b1;
    sb.push_back(vecs[i].e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL vec%0d.scoreboard: got empty queue required one entry", i);
    end else begin
      e = sb.pop_front();
      check_outputs($sformatf("vec%0d", i), e, 1'b1);
      last = e;
    end
  endtask
  initial begin
    vecs[0]  = '{36'h000000000, '{4'd0, 1'b1, 4'd0, 1'b1, 1'b0}};
    vecs[1]  = '{36'h571000000, '{4'd2, 1'b0, 4'd3, 1'b0, 1'b0}};
    vecs[2]  = '{36'h132000000, '{4'd4, 1'b1, 4'd6, 1'b1, 1'b0}};
    vecs[3]  = '{36'h891000000, '{4'd7, 1'b0, 4'd8, 1'b0, 1'b0}};
    vecs[4]  = '{36'h123000000, '{4'd3, 1'b1, 4'd6, 1'b1, 1'b0}};
    vecs[5]  = '{36'h987000000, '{4'd7, 1'b0, 4'd4, 1'b0, 1'b0}};
    vecs[6]  = '{36'h239000000, '{4'd5, 1'b1, 4'd4, 1'b0, 1'b0}};
    vecs[7]  = '{36'h276951438, '{4'd9, 1'b1, 4'd5, 1'b0, 1'b1}};
    vecs[8]  = '{36'h618753294, '{4'd7, 1'b1, 4'd5, 1'b0, 1'b1}};
    vecs[9]  = '{36'h112527829, '{4'd2, 1'b1, 4'd4, 1'b1, 1'b0}};
    vecs[10] = '{36'h924617379, '{4'd1, 1'b0, 4'd5, 1'b0, 1'b0}};
    vecs[11] = '{36'h012345678, '{4'd1, 1'b1, 4'd3, 1'b1, !RC}};
    vecs[12] = '{36'hC30000000, '{4'd5, 1'b0, 4'd5, 1'b0, 1'b0}};
    vecs[13] = '{36'h450000000, '{4'd9, 1'b1, 4'd9, 1'b1, 1'b0}};
    vecs[14] = '{36'hA0FEDCB12, '{4'd0, 1'b0, 4'd5, 1'b0, !RC}};
    vecs[15] = '{36'h123456789, '{4'd3, 1'b1, 4'd6, 1'b1, 1'b1}};
    vecs[16] = '{36'h123456788, '{4'd3, 1'b1, 4'd6, 1'b1, 1'b0}};
    zero = '0;
    last = '0;
    clock = 1'b0;
    en = 1'b0;
    reset = 1'b0;
    set_grid(36'h0);
    #3 reset = 1'b1;
    #1 check_outputs("reset_async", zero, 1'b0);
    en = 1'b1;
    set_grid(36'h276951438);
    @(posedge clock);
    #1 check_outputs("reset_en_held", zero, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    en = 1'b0;
    @(posedge clock);
    #1 check_outputs("after_reset_idle", zero, 1'b0);
    for (int i = 0; i < 16; i++) apply(i);
    @(negedge clock);
    en = 1'b0;
    set_grid(36'h999999999);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1 check_outputs($sformatf("hold%0d", k), last, 1'b1);
    end
    @(negedge clock);
    set_grid(36'h123456789);
    en = 1'b1;
    #2 reset = 1'b1;
    #1 check_outputs("reset_mid", zero, 1'b0);
    @(posedge clock);
    #1 check_outputs("reset_mid_edge", zero, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    en = 1'b0;
    @(posedge clock);
    #1 check_outputs("reset_mid_idle", zero, 1'b0);
    apply(16);
    apply(15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
